ctrl_pipeline: RTL and testbench

Parametrised control-bundle pipeline, successor to the fixed three-register E/M/W control chain in the CPU controller. It carries a decoded control word of CW bits plus a valid bit through NSTAGE registered stages. Each stage has its own stall and flush, stalls back-pressure upstream stages automatically, and a multi-cycle hold is built in for long-latency execute operations such as divide. It sits between the main/ALU decoders (decode stage) and the datapath stage consumers.

---
 rtl/ctrl_pipeline.sv | 138 +++++++++++++
 tb/tb_ctrl_pipeline.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: NSTAGE-deep control-word pipeline (stage 0 = execute) with
// per-stage stall/flush, automatic upstream back-pressure and a multi-cycle
// hold of stage 0 for long-latency operations.
// Optional build macro CTRL_PIPE_PERF_EN instantiates saturating bubble/stall
// performance counters; without it bubble_cnt and stall_cnt are tied to zero.
module ctrl_pipeline #(
  parameter int unsigned CW        = 11,
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned MC_CYCLES = 32,
  parameter int unsigned PERF_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CW-1:0]          in_ctrl,
  input  logic                   in_mc,
  input  logic [NSTAGE-1:0]      stall_i,
  input  logic [NSTAGE-1:0]      flush_i,
  output logic [NSTAGE*CW-1:0]   ctrl_q,
  output logic [NSTAGE-1:0]      valid_q,
  output logic                   stall_up,
  output logic                   mc_busy,
  output logic [PERF_W-1:0]      bubble_cnt,
  output logic [PERF_W-1:0]      stall_cnt
);

  localparam int unsigned MCW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_CYCLES - 1);

  logic [NSTAGE-1:0]    stall_eff;
  logic [NSTAGE-1:0]    valid_d;
  logic [NSTAGE*CW-1:0] ctrl_d;
  logic [MCW-1:0]       mc_cnt_q;
  logic [MCW-1:0]       mc_cnt_d;

  assign mc_busy  = (mc_cnt_q != '0);
  assign stall_up = stall_eff[0];

  // Effective stall: a stage is frozen if it or any downstream stage stalls;
  // stage 0 is also frozen while a multi-cycle op is resident.
  always_comb begin
    for (int k = 0; k < int'(NSTAGE); k++) begin
      stall_eff[k] = |(stall_i >> k);
    end
    stall_eff[0] = stall_eff[0] | mc_busy;
  end

  // Next-state for each stage: flush, else hold, else load upstream (or bubble).
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    mc_cnt_d = mc_cnt_q;

    if (flush_i[0]) begin
      valid_d[0]     = 1'b0;
      ctrl_d[0 +: CW] = '0;
    end else if (!stall_eff[0]) begin
      valid_d[0]     = in_valid;
      ctrl_d[0 +: CW] = in_valid ? in_ctrl : '0;
    end

    for (int k = 1; k < int'(NSTAGE); k++) begin
      if (flush_i[k]) begin
        valid_d[k]          = 1'b0;
        ctrl_d[k*CW +: CW]  = '0;
      end else if (!stall_eff[k]) begin
        if (stall_eff[k-1]) begin
          valid_d[k]         = 1'b0;
          ctrl_d[k*CW +: CW] = '0;
        end else begin
          valid_d[k]         = valid_q[k-1];
          ctrl_d[k*CW +: CW] = ctrl_q[(k-1)*CW +: CW];
        end
      end
    end

    // Multi-cycle residency counter; runs down regardless of downstream stalls.
    if (flush_i[0]) begin
      mc_cnt_d = '0;
    end else if (!stall_eff[0] && in_valid && in_mc && (MC_CYCLES > 1)) begin
      mc_cnt_d = MC_LOAD;
    end else if (mc_busy) begin
      mc_cnt_d = mc_cnt_q - MCW'(1);
    end
  end

  // Pipeline and multi-cycle state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      ctrl_q   <= '0;
      mc_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] bubble_q;
  logic [PERF_W-1:0] bubble_d;
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] stall_d;

  // Saturating counts of last-stage bubbles and upstream stall cycles.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (!valid_q[NSTAGE-1] && (bubble_q != PERF_MAX)) begin
      bubble_d = bubble_q + PERF_W'(1);
    end
    if (stall_up && (stall_q != PERF_MAX)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
`else
  assign bubble_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: scoreboard bench for ctrl_pipeline (NSTAGE=3, MC_CYCLES=4).
// Accepted ops are queued by a behavioural model; a monitor pops them as they
// reach the last stage. Per-cycle stage occupancy is also checked.
module tb_ctrl_pipeline;

  localparam int unsigned CW = 11;
  localparam int unsigned NS = 3;
  localparam int unsigned MC = 4;
  localparam int unsigned PW = 4;
  localparam int L    = 2;
  localparam int PMAX = 15;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [CW-1:0]     in_ctrl = '0;
  logic              in_mc = 1'b0;
  logic [NS-1:0]     stall_i = '0;
  logic [NS-1:0]     flush_i = '0;
  logic [NS*CW-1:0]  ctrl_q;
  logic [NS-1:0]     valid_q;
  logic              stall_up;
  logic              mc_busy;
  logic [PW-1:0]     bubble_cnt;
  logic [PW-1:0]     stall_cnt;

  ctrl_pipeline #(.CW(CW), .NSTAGE(NS), .MC_CYCLES(MC), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_mc(in_mc),
    .stall_i(stall_i), .flush_i(flush_i), .ctrl_q(ctrl_q), .valid_q(valid_q),
    .stall_up(stall_up), .mc_busy(mc_busy), .bubble_cnt(bubble_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: which op id sits in each stage, and busy cycles left.
  typedef struct { int id; logic [CW-1:0] ctrl; } op_t;
  op_t           exp_q[$];
  int            m_id[NS];
  logic [CW-1:0] m_ctrl[NS];
  int            mc_left;
  int            m_bub;
  int            m_stl;
  int            next_id;
  logic          su_seen;

  task automatic model_clear();
    for (int k = 0; k < int'(NS); k++) begin
      m_id[k] = -1;
      m_ctrl[k] = '0;
    end
    mc_left = 0;
    m_bub = 0;
    m_stl = 0;
    exp_q.delete();
  endtask

  // A stage is frozen when any stage at or after it stalls (or stage 0 busy).
  function automatic logic [NS-1:0] frozen(input logic [NS-1:0] st);
    logic [NS-1:0] r;
    for (int k = 0; k < int'(NS); k++) begin
      r[k] = 1'b0;
      for (int j = k; j < int'(NS); j++) if (st[j]) r[k] = 1'b1;
    end
    if (mc_left > 0) r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [NS-1:0] exp_valid();
    logic [NS-1:0] r;
    for (int k = 0; k < int'(NS); k++) r[k] = (m_id[k] >= 0);
    return r;
  endfunction

  function automatic logic [NS*CW-1:0] exp_ctrl();
    logic [NS*CW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(NS); k++) if (m_id[k] >= 0) r[k*CW +: CW] = m_ctrl[k];
    return r;
  endfunction

  task automatic drop_id(input int id);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].id == id) begin
        exp_q.delete(i);
        break;
      end
    end
  endtask

  task automatic model_step(input logic iv, input logic [CW-1:0] ic, input logic imc,
                            input logic [NS-1:0] st, input logic [NS-1:0] fl,
                            output logic acc);
    logic [NS-1:0] s;
    int            nid[NS];
    logic [CW-1:0] nc[NS];
    bit            found;
    op_t           o;
    s = frozen(st);
    if (m_id[L] < 0 && m_bub < PMAX) m_bub++;
    if (s[0] && m_stl < PMAX) m_stl++;
    acc = iv && !s[0] && !fl[0];
    for (int k = 0; k < int'(NS); k++) begin
      if (fl[k]) begin
        nid[k] = -1; nc[k] = '0;
      end else if (s[k]) begin
        nid[k] = m_id[k]; nc[k] = m_ctrl[k];
      end else if (k == 0) begin
        nid[k] = iv ? next_id : -1; nc[k] = iv ? ic : '0;
      end else if (s[k-1]) begin
        nid[k] = -1; nc[k] = '0;
      end else begin
        nid[k] = m_id[k-1]; nc[k] = m_ctrl[k-1];
      end
    end
    if (fl[0]) mc_left = 0;
    else if (acc && imc) mc_left = int'(MC) - 1;
    else if (mc_left > 0) mc_left--;
    if (acc) begin
      o.id = next_id; o.ctrl = ic;
      exp_q.push_back(o);
      next_id++;
    end
    // Ops that vanished before reaching the last stage are no longer expected.
    for (int k = 0; k < L; k++) begin
      if (m_id[k] >= 0) begin
        found = 0;
        for (int j = 0; j < int'(NS); j++) if (nid[j] == m_id[k]) found = 1;
        if (!found) drop_id(m_id[k]);
      end
    end
    for (int k = 0; k < int'(NS); k++) begin
      m_id[k] = nid[k]; m_ctrl[k] = nc[k];
    end
  endtask

  // One clock: drive, check stall_up, advance model at the edge, check state.
  task automatic cyc(input logic iv, input logic [CW-1:0] ic, input logic imc,
                     input logic [NS-1:0] st, input logic [NS-1:0] fl, output logic acc);
    logic [NS-1:0] s;
    in_valid = iv; in_ctrl = ic; in_mc = imc; stall_i = st; flush_i = fl;
    #1;
    s = frozen(st);
    su_seen = stall_up;
    chk("stall_up", 64'(stall_up), 64'(s[0]));
    @(posedge clk);
    model_step(iv, ic, imc, st, fl, acc);
    @(negedge clk);
    chk("valid_q", 64'(valid_q), 64'(exp_valid()));
    chk("ctrl_q", 64'(ctrl_q), 64'(exp_ctrl()));
    chk("mc_busy", 64'(mc_busy), 64'(mc_left > 0));
    chk("bubble_cnt", 64'(bubble_cnt), PERF ? 64'(m_bub) : 64'd0);
    chk("stall_cnt", 64'(stall_cnt), PERF ? 64'(m_stl) : 64'd0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_mc = 0; in_ctrl = '0; stall_i = '0; flush_i = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_q), 64'd0);
    chk("rst_ctrl", 64'(ctrl_q), 64'd0);
    chk("rst_mc_busy", 64'(mc_busy), 64'd0);
    chk("rst_stall_up", 64'(stall_up), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pop the oldest expected op whenever one lands in the last stage.
  initial begin : monitor
    logic ld;
    op_t  o;
    forever begin
      @(posedge clk);
      ld = rst && !stall_i[L] && !flush_i[L];
      #1;
      if (ld && valid_q[L]) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: unexpected op %0h at %0t", ctrl_q[L*CW +: CW], $time);
        end else begin
          o = exp_q.pop_front();
          chk("sb_ctrl", 64'(ctrl_q[L*CW +: CW]), 64'(o.ctrl));
        end
      end
    end
  end

  initial begin : stim
    logic          acc;
    logic          r_v, r_m, hold;
    logic [CW-1:0] r_c;
    logic [NS-1:0] r_st, r_fl;
    int            acc_at, nb;
    next_id = 0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Idle after reset: bubble counter saturates, no stalls counted.
    repeat (20) cyc(0, '0, 0, '0, '0, acc);
    chk("perf_bubble_sat", 64'(bubble_cnt), PERF ? 64'd15 : 64'd0);
    chk("perf_stall_zero", 64'(stall_cnt), 64'd0);

    // Back-to-back flow.
    cyc(1, 11'h001, 0, '0, '0, acc);
    cyc(1, 11'h002, 0, '0, '0, acc);
    cyc(1, 11'h003, 0, '0, '0, acc);
    chk("flow_s2_a", 64'(ctrl_q[2*CW +: CW]), 64'h001);
    cyc(0, '0, 0, '0, '0, acc);
    chk("flow_s2_b", 64'(ctrl_q[2*CW +: CW]), 64'h002);
    cyc(0, '0, 0, '0, '0, acc);
    chk("flow_s2_c", 64'(ctrl_q[2*CW +: CW]), 64'h003);

    // Downstream stall of stage 1 with A in stage 0, B in stage 1.
    cyc(1, 11'h0B0, 0, '0, '0, acc);
    cyc(1, 11'h0A0, 0, '0, '0, acc);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 11'h0C0, 0, 3'b010, '0, acc);
      chk("dstall_up", 64'(su_seen), 64'd1);
      chk("dstall_acc", 64'(acc), 64'd0);
      chk("dstall_s0", 64'(ctrl_q[0 +: CW]), 64'h0A0);
      chk("dstall_s1", 64'(ctrl_q[CW +: CW]), 64'h0B0);
      chk("dstall_s2_bubble", 64'(valid_q[2]), 64'd0);
    end
    cyc(1, 11'h0C0, 0, '0, '0, acc);
    chk("dstall_c_taken", 64'(acc), 64'd1);
    repeat (3) cyc(0, '0, 0, '0, '0, acc);

    // Flush beats stall on stage 0.
    cyc(1, 11'h055, 0, '0, '0, acc);
    cyc(0, '0, 0, 3'b001, 3'b001, acc);
    for (int i = 0; i < 2; i++) begin
      cyc(0, '0, 0, 3'b001, '0, acc);
      chk("fvs_s0_valid", 64'(valid_q[0]), 64'd0);
      chk("fvs_s0_ctrl", 64'(ctrl_q[0 +: CW]), 64'd0);
    end
    repeat (3) cyc(0, '0, 0, '0, '0, acc);

    // Multi-cycle op D followed by E.
    cyc(1, 11'h0D0, 1, '0, '0, acc);
    nb = mc_busy ? 1 : 0;
    acc_at = -1;
    for (int i = 0; i < 8 && acc_at < 0; i++) begin
      cyc(1, 11'h0E0, 0, '0, '0, acc);
      if (acc) acc_at = i + 1;
      else begin
        if (mc_busy) nb++;
        chk("mc_d_resident", 64'(ctrl_q[0 +: CW]), 64'h0D0);
      end
    end
    chk("mc_e_edge", 64'(acc_at), 64'd4);
    chk("mc_busy_cycles", 64'(nb), 64'd3);
    repeat (3) cyc(0, '0, 0, '0, '0, acc);

    // Multi-cycle op flushed on its second busy cycle.
    cyc(1, 11'h0F0, 1, '0, '0, acc);
    cyc(0, '0, 0, '0, '0, acc);
    cyc(0, '0, 0, '0, 3'b001, acc);
    chk("mcf_busy", 64'(mc_busy), 64'd0);
    chk("mcf_s0_bubble", 64'(valid_q[0]), 64'd0);
    cyc(1, 11'h077, 0, '0, '0, acc);
    chk("mcf_next_acc", 64'(acc), 64'd1);
    chk("mcf_next_s0", 64'(ctrl_q[0 +: CW]), 64'h077);

    // Randomised traffic; a refused op is re-presented until taken.
    hold = 0; r_v = 0; r_c = '0; r_m = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        r_v = ($urandom_range(0, 99) < 70);
        r_c = CW'($urandom);
        r_m = ($urandom_range(0, 99) < 10);
      end
      r_st = '0; r_fl = '0;
      for (int k = 0; k < int'(NS); k++) begin
        r_st[k] = ($urandom_range(0, 99) < 8);
        r_fl[k] = ($urandom_range(0, 99) < 4);
      end
      cyc(r_v, r_c, r_m, r_st, r_fl, acc);
      hold = r_v && !acc;
    end

    // Reset mid-stream, then refill and drain.
    cyc(1, 11'h123, 0, '0, '0, acc);
    cyc(1, 11'h321, 0, '0, '0, acc);
    do_reset();
    cyc(1, 11'h111, 0, '0, '0, acc);
    cyc(1, 11'h222, 1, '0, '0, acc);
    repeat (10) cyc(0, '0, 0, '0, '0, acc);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
